// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Multicycle RV32I control unit. It steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every datapath
// enable and select. Instruction and data memory accesses wait for a
// ready handshake, and a wait that runs too long is treated as a bus error.
// Illegal opcodes and bus errors both end in a TRAP state, which only
// reset can leave.
//
// Registered state: the FSM state, the memory-wait counter, and the sticky
// illegal and bus_err flags. All other outputs are decoded combinationally
// from the state, the instruction fields and the ALU flags.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   opcode/funct3/funct7_5 instruction register fields
//   alu_flags             {carry, overflow, msb, zero} from the ALU
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, ir_we       instruction fetch request / IR latch enable
//   dmem_req, dmem_we     data access request / write qualifier
//   alu_src_a/_b, alu_cmd ALU operand selects and operation
//   rf_we, rf_src         register-file write enable / write-data select
//   pc_we, pc_src         PC update enable / next-PC select
//   illegal, bus_err      sticky trap causes
//   state_o               current state code (debug)
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter bit HAS_LUI     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic [3:0] alu_flags,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_cmd,
    output logic       rf_we,
    output logic [1:0] rf_src,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state_reg;
    logic [TO_W-1:0] cnt_reg;
    logic            illegal_reg;
    logic            bus_err_reg;

    // Instruction class decode
    logic is_r, is_i, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_auipc, is_lui, is_legal;
    logic timeout_hit, br_taken, lt_signed;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign is_lui    = HAS_LUI && (opcode == OP_LUI);

    // funct3 010/011 are not defined for branches
    assign is_legal = is_r || is_i || is_load || is_store || is_jal || is_jalr
                   || is_auipc || is_lui
                   || (is_branch && (funct3[2:1] != 2'b01));

    // Limit only applies when enabled; a ready in the same cycle overrides it
    assign timeout_hit = (MEM_TIMEOUT > 0) && (cnt_reg == TO_LIMIT);

    assign lt_signed = alu_flags[1] ^ alu_flags[2];

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = alu_flags[0];
            3'b001:  br_taken = !alu_flags[0];
            3'b100:  br_taken = lt_signed;
            3'b101:  br_taken = !lt_signed;
            3'b110:  br_taken = !alu_flags[3];
            3'b111:  br_taken = alu_flags[3];
            default: br_taken = 1'b0;
        endcase
    end

    // Shared R/I ALU mapping; only R-type turns funct3 000 into SUB
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7,
                                              input logic       r_type);
        case (f3)
            3'b000:  return (r_type && f7) ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return f7 ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_reg <= S_DECODE;
                    end else if (timeout_hit) begin
                        bus_err_reg <= 1'b1;
                        state_reg   <= S_TRAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        illegal_reg <= 1'b1;
                        state_reg   <= S_TRAP;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_reg <= '0;
                    if (is_load || is_store) begin
                        state_reg <= S_MEM;
                    end else if (is_branch) begin
                        state_reg <= S_FETCH;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cnt_reg   <= '0;
                        state_reg <= is_load ? S_WB : S_FETCH;
                    end else if (timeout_hit) begin
                        bus_err_reg <= 1'b1;
                        state_reg   <= S_TRAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_WB: begin
                    cnt_reg   <= '0;
                    state_reg <= S_FETCH;
                end
                S_TRAP:  state_reg <= S_TRAP;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_cmd   = 4'd0;
        rf_we     = 1'b0;
        rf_src    = 2'd0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_cmd = alu_decode(funct3, funct7_5, 1'b1);
                end else if (is_i) begin
                    alu_cmd   = alu_decode(funct3, funct7_5, 1'b0);
                    alu_src_b = 2'd1;
                end else if (is_load || is_store || is_jalr) begin
                    alu_src_b = 2'd1;
                end else if (is_auipc) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                end else if (is_branch) begin
                    alu_cmd = 4'd1;
                    pc_we   = 1'b1;
                    pc_src  = br_taken ? 2'd1 : 2'd0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_we    = is_store && dmem_ready;
            end
            S_WB: begin
                rf_we = 1'b1;
                pc_we = 1'b1;
                if (is_load)                rf_src = 2'd1;
                else if (is_jal || is_jalr) rf_src = 2'd2;
                else if (is_lui)            rf_src = 2'd3;
                if (is_jal)       pc_src = 2'd1;
                else if (is_jalr) pc_src = 2'd2;
            end
            default: ;
        endcase
        // No strobe may leak out while reset is being held
        if (!rst_n) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            rf_we    = 1'b0;
            pc_we    = 1'b0;
        end
    end

    assign illegal = illegal_reg;
    assign bus_err = bus_err_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
module tb_rv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [3:0] alu_flags;
    logic       imem_ready;
    logic       dmem_ready;

    logic       imem_req, ir_we, dmem_req, dmem_we, alu_src_a, rf_we, pc_we;
    logic       illegal, bus_err;
    logic [1:0] alu_src_b, rf_src, pc_src;
    logic [3:0] alu_cmd;
    logic [2:0] state_o;

    logic       n_imem_req, n_ir_we, n_dmem_req, n_dmem_we, n_alu_src_a;
    logic       n_rf_we, n_pc_we, n_illegal, n_bus_err;
    logic [1:0] n_alu_src_b, n_rf_src, n_pc_src;
    logic [3:0] n_alu_cmd;
    logic [2:0] n_state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4), .HAS_LUI(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_flags(alu_flags),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_cmd(alu_cmd), .rf_we(rf_we), .rf_src(rf_src), .pc_we(pc_we),
        .pc_src(pc_src), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o)
    );

    rv_multicycle_ctrl #(.MEM_TIMEOUT(15), .TO_W(4), .HAS_LUI(1'b0)) dut_nolui (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_flags(alu_flags),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(n_imem_req), .ir_we(n_ir_we), .dmem_req(n_dmem_req),
        .dmem_we(n_dmem_we), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
        .alu_cmd(n_alu_cmd), .rf_we(n_rf_we), .rf_src(n_rf_src),
        .pc_we(n_pc_we), .pc_src(n_pc_src), .illegal(n_illegal),
        .bus_err(n_bus_err), .state_o(n_state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    // Non-memory, non-branch instruction with immediate readies: F D E WB
    task automatic run_simple(input string name, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7,
                              input int e_cmd, input int e_a, input int e_b,
                              input int e_rfsrc, input int e_pcsrc);
        set_instr(op, f3, f7);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        settle();
        chk({name, ".f_state"}, 32'(state_o), 0);
        chk({name, ".f_ir_we"}, 32'(ir_we), 1);
        tick();
        chk({name, ".d_state"}, 32'(state_o), 1);
        chk({name, ".d_pc_we"}, 32'(pc_we), 0);
        tick();
        chk({name, ".e_state"}, 32'(state_o), 2);
        chk({name, ".e_cmd"}, 32'(alu_cmd), 32'(e_cmd));
        chk({name, ".e_src_a"}, 32'(alu_src_a), 32'(e_a));
        chk({name, ".e_src_b"}, 32'(alu_src_b), 32'(e_b));
        chk({name, ".e_rf_we"}, 32'(rf_we), 0);
        chk({name, ".e_pc_we"}, 32'(pc_we), 0);
        tick();
        chk({name, ".w_state"}, 32'(state_o), 4);
        chk({name, ".w_rf_we"}, 32'(rf_we), 1);
        chk({name, ".w_rf_src"}, 32'(rf_src), 32'(e_rfsrc));
        chk({name, ".w_pc_we"}, 32'(pc_we), 1);
        chk({name, ".w_pc_src"}, 32'(pc_src), 32'(e_pcsrc));
        tick();
        chk({name, ".next_state"}, 32'(state_o), 0);
        chk({name, ".next_rf_we"}, 32'(rf_we), 0);
        $display("[TB] %s retired", name);
    endtask

    task automatic run_branch(input string name, input logic [2:0] f3,
                              input logic [3:0] flags, input int e_pcsrc);
        set_instr(7'b1100011, f3, 1'b0);
        alu_flags  = flags;
        imem_ready = 1'b1;
        settle();
        chk({name, ".f_state"}, 32'(state_o), 0);
        tick();
        chk({name, ".d_state"}, 32'(state_o), 1);
        tick();
        chk({name, ".e_state"}, 32'(state_o), 2);
        chk({name, ".e_cmd"}, 32'(alu_cmd), 1);
        chk({name, ".e_pc_we"}, 32'(pc_we), 1);
        chk({name, ".e_pc_src"}, 32'(pc_src), 32'(e_pcsrc));
        chk({name, ".e_rf_we"}, 32'(rf_we), 0);
        tick();
        chk({name, ".next_state"}, 32'(state_o), 0);
        chk({name, ".next_rf_we"}, 32'(rf_we), 0);
        alu_flags = 4'b0000;
        $display("[TB] %s retired", name);
    endtask

    initial begin
        int req_cycles;
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        alu_flags  = 4'b0000;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // Reset state, with strobes forced low while rst_n is low
        tick();
        tick();
        chk("rst.state", 32'(state_o), 0);
        chk("rst.illegal", 32'(illegal), 0);
        chk("rst.bus_err", 32'(bus_err), 0);
        chk("rst.imem_req", 32'(imem_req), 0);
        chk("rst.ir_we", 32'(ir_we), 0);
        rst_n = 1'b1;
        settle();
        chk("rst.release_imem_req", 32'(imem_req), 1);
        $display("[TB] reset done");

        // ALU, jump and upper-immediate instructions
        run_simple("SUB",   7'b0110011, 3'b000, 1'b1, 1, 0, 0, 0, 0);
        run_simple("ADD",   7'b0110011, 3'b000, 1'b0, 0, 0, 0, 0, 0);
        run_simple("ADDI7", 7'b0010011, 3'b000, 1'b1, 0, 0, 1, 0, 0);
        run_simple("SRAI",  7'b0010011, 3'b101, 1'b1, 7, 0, 1, 0, 0);
        run_simple("SRL",   7'b0110011, 3'b101, 1'b0, 6, 0, 0, 0, 0);
        run_simple("SLTU",  7'b0110011, 3'b011, 1'b0, 4, 0, 0, 0, 0);
        run_simple("AND",   7'b0110011, 3'b111, 1'b0, 9, 0, 0, 0, 0);
        run_simple("AUIPC", 7'b0010111, 3'b000, 1'b0, 0, 1, 1, 0, 0);
        run_simple("JAL",   7'b1101111, 3'b000, 1'b0, 0, 0, 0, 2, 1);
        run_simple("JALR",  7'b1100111, 3'b000, 1'b0, 0, 0, 1, 2, 2);

        // Branch conditions
        run_branch("BLTU_c0", 3'b110, 4'b0000, 1);
        run_branch("BGEU_c0", 3'b111, 4'b0000, 0);
        run_branch("BEQ_z1",  3'b000, 4'b0001, 1);
        run_branch("BNE_z1",  3'b001, 4'b0001, 0);
        run_branch("BLT_m1",  3'b100, 4'b0010, 1);
        run_branch("BGE_mo",  3'b101, 4'b0110, 1);

        // Load with three wait cycles in MEM: 8 cycles total
        set_instr(7'b0000011, 3'b010, 1'b0);
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        req_cycles = 0;
        settle();
        chk("LW.f_state", 32'(state_o), 0);
        tick();
        tick();
        chk("LW.e_state", 32'(state_o), 2);
        chk("LW.e_src_b", 32'(alu_src_b), 1);
        chk("LW.e_cmd", 32'(alu_cmd), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("LW.m_wait_state", 32'(state_o), 3);
            chk("LW.m_wait_we", 32'(dmem_we), 0);
            chk("LW.m_wait_pc_we", 32'(pc_we), 0);
            if (dmem_req) req_cycles++;
            tick();
        end
        dmem_ready = 1'b1;
        settle();
        chk("LW.m_ready_state", 32'(state_o), 3);
        if (dmem_req) req_cycles++;
        chk("LW.req_cycles", 32'(req_cycles), 4);
        tick();
        chk("LW.w_state", 32'(state_o), 4);
        chk("LW.w_rf_src", 32'(rf_src), 1);
        chk("LW.w_rf_we", 32'(rf_we), 1);
        chk("LW.w_pc_we", 32'(pc_we), 1);
        tick();
        chk("LW.next_state", 32'(state_o), 0);
        $display("[TB] LW retired");

        // Store with immediate ready: 4 cycles, pc update in MEM
        set_instr(7'b0100011, 3'b010, 1'b0);
        settle();
        tick();
        tick();
        tick();
        chk("SW.m_state", 32'(state_o), 3);
        chk("SW.m_dmem_we", 32'(dmem_we), 1);
        chk("SW.m_pc_we", 32'(pc_we), 1);
        chk("SW.m_pc_src", 32'(pc_src), 0);
        tick();
        chk("SW.next_state", 32'(state_o), 0);
        chk("SW.next_rf_we", 32'(rf_we), 0);
        $display("[TB] SW retired");

        // LUI: legal in the main instance, illegal without HAS_LUI
        run_simple("LUI", 7'b0110111, 3'b000, 1'b0, 0, 0, 0, 3, 0);
        chk("LUI.nolui_state", 32'(n_state_o), 5);
        chk("LUI.nolui_illegal", 32'(n_illegal), 1);
        chk("LUI.nolui_imem_req", 32'(n_imem_req), 0);

        // Branch funct3 010 is illegal and traps
        set_instr(7'b1100011, 3'b010, 1'b0);
        settle();
        tick();
        tick();
        chk("BILL.state", 32'(state_o), 5);
        chk("BILL.illegal", 32'(illegal), 1);
        tick();
        chk("BILL.stay_state", 32'(state_o), 5);
        chk("BILL.imem_req", 32'(imem_req), 0);
        rst_n = 1'b0;
        tick();
        chk("BILL.rst_state", 32'(state_o), 0);
        chk("BILL.rst_illegal", 32'(illegal), 0);
        chk("BILL.rst_nolui_illegal", 32'(n_illegal), 0);
        rst_n = 1'b1;
        $display("[TB] illegal branch trapped");

        // Ready arriving exactly at the limit wins
        set_instr(7'b0110011, 3'b000, 1'b0);
        imem_ready = 1'b0;
        settle();
        for (int i = 0; i < 15; i++) begin
            chk("TO_EDGE.wait_state", 32'(state_o), 0);
            tick();
        end
        imem_ready = 1'b1;
        settle();
        chk("TO_EDGE.ir_we", 32'(ir_we), 1);
        tick();
        chk("TO_EDGE.state", 32'(state_o), 1);
        chk("TO_EDGE.bus_err", 32'(bus_err), 0);
        tick();
        tick();
        tick();
        chk("TO_EDGE.back_fetch", 32'(state_o), 0);
        $display("[TB] fetch at limit accepted");

        // Sixteen FETCH cycles without ready raise bus_err
        imem_ready = 1'b0;
        settle();
        for (int i = 0; i < 16; i++) begin
            chk("TO.wait_state", 32'(state_o), 0);
            tick();
        end
        chk("TO.state", 32'(state_o), 5);
        chk("TO.bus_err", 32'(bus_err), 1);
        chk("TO.imem_req", 32'(imem_req), 0);
        imem_ready = 1'b1;
        tick();
        chk("TO.hold_state", 32'(state_o), 5);
        chk("TO.hold_bus_err", 32'(bus_err), 1);
        rst_n = 1'b0;
        tick();
        chk("TO.rst_state", 32'(state_o), 0);
        chk("TO.rst_bus_err", 32'(bus_err), 0);
        rst_n = 1'b1;
        $display("[TB] fetch timeout trapped");

        // Reset during a stalled store in MEM
        set_instr(7'b0100011, 3'b000, 1'b0);
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        settle();
        tick();
        tick();
        tick();
        chk("SWRST.m_state", 32'(state_o), 3);
        chk("SWRST.m_req", 32'(dmem_req), 1);
        chk("SWRST.m_we", 32'(dmem_we), 1);
        tick();
        rst_n = 1'b0;
        settle();
        chk("SWRST.rst_req", 32'(dmem_req), 0);
        chk("SWRST.rst_we", 32'(dmem_we), 0);
        chk("SWRST.rst_pc_we", 32'(pc_we), 0);
        chk("SWRST.rst_rf_we", 32'(rf_we), 0);
        tick();
        chk("SWRST.state", 32'(state_o), 0);
        chk("SWRST.pc_we", 32'(pc_we), 0);
        rst_n = 1'b1;
        settle();
        chk("SWRST.fetch_req", 32'(imem_req), 1);
        chk("SWRST.fetch_pc_we", 32'(pc_we), 0);
        $display("[TB] store aborted by reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
- Parametrised multicycle RV32I control unit that sequences fetch/decode/execute/memory/write-back for the single-ALU datapath.
- Adds the following over the fixed-timing controller:
  - full funct3/funct7 ALU decode;
  - all six branch conditions evaluated from ALU flags;
  - variable-latency instruction/data memory handshakes with timeout;
  - optional LUI;
  - a sticky trap state for illegal opcodes and bus errors.
- Sits between the instruction register/ALU flags and every datapath enable/select.

Parameters:
- MEM_TIMEOUT, 15, max wait cycles with req high and ready low before bus error; 0 disables the timeout.
- TO_W, 4, width of the timeout counter; must hold MEM_TIMEOUT.
- HAS_LUI, 1, 1 makes opcode 0110111 legal; 0 traps it as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- alu_flags  in  4  bit0 zero, bit1 msb, bit2 overflow, bit3 carry (1 = no borrow on SUB).
- imem_ready  in  1  instruction-memory data valid.
- dmem_ready  in  1  data-memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  latch instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (valid with dmem_req).
- alu_src_a  out  1  0 rs1, 1 pc.
- alu_src_b  out  2  0 rs2, 1 imm, 2 constant 4.
- alu_cmd  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- rf_we  out  1  register-file write.
- rf_src  out  2  0 alu, 1 dmem, 2 pc+4, 3 imm.
- pc_we  out  1  PC update.
- pc_src  out  2  0 pc+4, 1 pc+imm, 2 alu_result with bit0 cleared.
- illegal  out  1  sticky illegal-instruction flag.
- bus_err  out  1  sticky memory-timeout flag.
- state_o  out  3  current state code, for debug.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Only state, timeout counter, illegal and bus_err are registered. All other outputs are combinational from state, opcode, funct fields and flags; every output not listed for a state is 0.
- Reset (rst_n low at a clock edge):
  - state <= FETCH, counter <= 0, illegal <= 0, bus_err <= 0;
  - while rst_n is low, all strobes (imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we) are forced to 0.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_we=1, go to DECODE.
- DECODE:
  - Legal opcodes: 0110011 R, 0010011 ALU-I, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR, 0010111 AUIPC, and 0110111 LUI if HAS_LUI.
  - Branch with funct3 010 or 011 is illegal.
  - On illegal: illegal <= 1, go to TRAP. Otherwise go to EXEC.
- EXEC:
  - R: src_a=0, src_b=0. alu_cmd from funct3 (000 ADD/SUB by funct7_5, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7_5, 110 OR, 111 AND).
  - ALU-I: same mapping with src_b=1; funct7_5 is used only for funct3 101 (ADDI never becomes SUB).
  - Load/store: ADD, src_b=1. Go to MEM.
  - AUIPC: ADD, src_a=1, src_b=1.
  - JALR: ADD, src_b=1.
  - JAL/LUI: ALU unused, alu_cmd=0.
  - Branch: SUB, src_a=0, src_b=0. taken = BEQ zero, BNE !zero, BLT msb^ovf, BGE !(msb^ovf), BLTU !carry, BGEU carry. Set pc_we=1, pc_src = taken ? 1 : 0, go to FETCH (no WB).
  - All other classes go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for store. Address/data inputs are held stable by the datapath.
  - On dmem_ready: load goes to WB; store sets pc_we=1, pc_src=0 and goes to FETCH.
- WB:
  - rf_we=1 for exactly one cycle. rf_src: R/I/AUIPC 0, load 1, JAL/JALR 2, LUI 3.
  - pc_we=1 with pc_src: JAL 1, JALR 2, else 0.
  - Go to FETCH.
- Timeout:
  - Counter clears on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with ready low.
  - If ready is low while counter == MEM_TIMEOUT (MEM_TIMEOUT>0): bus_err <= 1, go to TRAP.
  - Ready arriving in the same cycle as the limit wins (no error).
- TRAP: all strobes 0; stays in TRAP until reset; flags remain held.
- Latency (ready asserted on first request cycle):
  - ALU/jump/LUI: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Exactly one pc_we pulse per retired instruction.

Test Plan:
- SUB x3,x1,x2 (opcode 0110011, funct3 000, funct7_5 1), readies immediate → state_o 0,1,2,4; alu_cmd=1 in EXEC; rf_we=1, rf_src=0, pc_we=1, pc_src=0 in WB only; back to FETCH on cycle 5.
- BLTU with flags carry=0, then BGEU with carry=0 → first gives pc_src=1, second gives pc_src=0; pc_we=1 in EXEC both times; rf_we never asserted.
- LW with dmem_ready low 3 cycles in MEM → dmem_req high 4 cycles, dmem_we=0; WB has rf_src=1; total 8 cycles.
- imem_ready held low, MEM_TIMEOUT=15 → bus_err set after 16 FETCH cycles, state_o=5; stays there ignoring ready until rst_n=0 clears it to FETCH with bus_err=0.
- Opcode 0110111 with HAS_LUI=0 → illegal=1, TRAP; with HAS_LUI=1 → WB with rf_src=3; branch funct3 010 → illegal.
- rst_n low for one edge during a store's MEM with dmem_ready low → dmem_req/dmem_we drop while rst_n is low; next state FETCH; no pc_we or rf_we pulse.
